// File: rtl/countdown_timer_ms_if.sv
// Control, preset and display signals shared by the countdown timer and its driver.
interface countdown_timer_ms_if;
    logic       load_i;
    logic       start_stop_i;
    logic [4:0] Hourset;
    logic [5:0] Minset;
    logic [5:0] Secset;
    logic [4:0] hour_o;
    logic [5:0] min_o;
    logic [5:0] sec_o;
    logic [9:0] ms_o;
    logic       expired_o;
    logic       alarm_o;

    modport master (
        output load_i, start_stop_i, Hourset, Minset, Secset,
        input  hour_o, min_o, sec_o, ms_o, expired_o, alarm_o
    );

    modport slave (
        input  load_i, start_stop_i, Hourset, Minset, Secset,
        output hour_o, min_o, sec_o, ms_o, expired_o, alarm_o
    );
endinterface

// File: rtl/countdown_timer_ms.sv
// Hour/minute/second/millisecond countdown timer with expiry flag and one-cycle alarm.
module countdown_timer_ms #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    countdown_timer_ms_if.slave        bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

    state_e        state_q;
    logic [PW-1:0] pre_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic [9:0]    ms_q;
    logic          expired_q;
    logic          alarm_q;

    logic [4:0]    hour_set;
    logic [5:0]    min_set;
    logic [5:0]    sec_set;
    logic [4:0]    dec_hour;
    logic [5:0]    dec_min;
    logic [5:0]    dec_sec;
    logic [9:0]    dec_ms;
    logic          tick;
    logic          count_zero;
    logic          dec_zero;

    always_comb begin
        hour_set = (bus.Hourset > 5'd23) ? 5'd23 : bus.Hourset;
        min_set  = (bus.Minset  > 6'd59) ? 6'd59 : bus.Minset;
        sec_set  = (bus.Secset  > 6'd59) ? 6'd59 : bus.Secset;
    end

    // Borrow chain; only ever applied to a non-zero count, so hour never underflows.
    always_comb begin
        dec_hour = hour_q;
        dec_min  = min_q;
        dec_sec  = sec_q;
        dec_ms   = ms_q;
        if (ms_q != 10'd0) begin
            dec_ms = ms_q - 10'd1;
        end else begin
            dec_ms = 10'd999;
            if (sec_q != 6'd0) begin
                dec_sec = sec_q - 6'd1;
            end else begin
                dec_sec = 6'd59;
                if (min_q != 6'd0) begin
                    dec_min = min_q - 6'd1;
                end else begin
                    dec_min  = 6'd59;
                    dec_hour = hour_q - 5'd1;
                end
            end
        end
    end

    assign tick       = (state_q == StRun) && (pre_q == PreMax);
    assign count_zero = ~|{hour_q, min_q, sec_q, ms_q};
    assign dec_zero   = ~|{dec_hour, dec_min, dec_sec, dec_ms};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            ms_q      <= '0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else if (bus.load_i) begin
            state_q   <= StIdle;
            pre_q     <= '0;
            hour_q    <= hour_set;
            min_q     <= min_set;
            sec_q     <= sec_set;
            ms_q      <= 10'd0;
            expired_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            alarm_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    pre_q <= '0;
                    if (bus.start_stop_i && !count_zero) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (tick) begin
                        hour_q <= dec_hour;
                        min_q  <= dec_min;
                        sec_q  <= dec_sec;
                        ms_q   <= dec_ms;
                        pre_q  <= '0;
                    end else if (bus.start_stop_i) begin
                        pre_q <= pre_q + PW'(1);
                    end else begin
                        pre_q <= '0;
                    end
                    // Reaching zero takes precedence over a simultaneous pause.
                    if (tick && dec_zero) begin
                        state_q   <= StExpired;
                        expired_q <= 1'b1;
                        alarm_q   <= 1'b1;
                    end else if (!bus.start_stop_i) begin
                        state_q <= StIdle;
                    end
                end
                StExpired: begin
                    pre_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    pre_q   <= '0;
                end
            endcase
        end
    end

    assign bus.hour_o    = hour_q;
    assign bus.min_o     = min_q;
    assign bus.sec_o     = sec_q;
    assign bus.ms_o      = ms_q;
    assign bus.expired_o = expired_q;
    assign bus.alarm_o   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ms.sv
// Directed checks of countdown_timer_ms at TICK_DIV = 1 (dut_a) and TICK_DIV = 4 (dut_b).
module tb_countdown_timer_ms;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    countdown_timer_ms_if a ();
    countdown_timer_ms_if b ();

    countdown_timer_ms #(.TICK_DIV(1)) dut_a (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (a.slave)
    );

    countdown_timer_ms #(.TICK_DIV(4)) dut_b (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (b.slave)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int unsigned h, input int unsigned m, input int unsigned s);
        a.Hourset = 5'(h);
        a.Minset  = 6'(m);
        a.Secset  = 6'(s);
        a.load_i  = 1'b1;
        step(1);
        a.load_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        a.load_i = 0; a.start_stop_i = 0; a.Hourset = 0; a.Minset = 0; a.Secset = 0;
        b.load_i = 0; b.start_stop_i = 0; b.Hourset = 0; b.Minset = 0; b.Secset = 0;
        step(2);
        rst = 1'b0;
        check_eq("rst_hour", a.hour_o, 0);
        check_eq("rst_ms", a.ms_o, 0);
        check_eq("rst_expired", a.expired_o, 0);
        check_eq("rst_alarm", a.alarm_o, 0);

        // Clamping of out-of-range presets
        load_a(31, 63, 60);
        check_eq("clamp_hour", a.hour_o, 23);
        check_eq("clamp_min", a.min_o, 59);
        check_eq("clamp_sec", a.sec_o, 59);
        check_eq("clamp_ms", a.ms_o, 0);

        // Full borrow 1:00:00 -> 0:59:59.999; pause on the tick edge still decrements
        load_a(1, 0, 0);
        a.start_stop_i = 1'b1;
        step(1);
        check_eq("borrow_entry_ms", a.ms_o, 0);
        a.start_stop_i = 1'b0;
        step(1);
        check_eq("borrow_hour", a.hour_o, 0);
        check_eq("borrow_min", a.min_o, 59);
        check_eq("borrow_sec", a.sec_o, 59);
        check_eq("borrow_ms", a.ms_o, 999);
        step(3);
        check_eq("held_ms", a.ms_o, 999);

        load_a(0, 1, 0);
        a.start_stop_i = 1'b1;
        step(1);
        a.start_stop_i = 1'b0;
        step(1);
        check_eq("min_borrow_min", a.min_o, 0);
        check_eq("min_borrow_sec", a.sec_o, 59);
        check_eq("min_borrow_ms", a.ms_o, 999);

        // Expiry 1000 edges after RUN entry
        load_a(0, 0, 1);
        a.start_stop_i = 1'b1;
        step(1);
        step(999);
        check_eq("pre_exp_ms", a.ms_o, 1);
        check_eq("pre_exp_expired", a.expired_o, 0);
        check_eq("pre_exp_alarm", a.alarm_o, 0);
        step(1);
        check_eq("exp_ms", a.ms_o, 0);
        check_eq("exp_sec", a.sec_o, 0);
        check_eq("exp_expired", a.expired_o, 1);
        check_eq("exp_alarm", a.alarm_o, 1);
        step(1);
        check_eq("alarm_one_cycle", a.alarm_o, 0);
        check_eq("exp_hold", a.expired_o, 1);
        a.start_stop_i = 1'b0;
        step(2);
        a.start_stop_i = 1'b1;
        step(2);
        check_eq("exp_toggle_expired", a.expired_o, 1);
        check_eq("exp_toggle_alarm", a.alarm_o, 0);
        check_eq("exp_toggle_ms", a.ms_o, 0);

        // Load on the expiry-tick edge wins
        a.start_stop_i = 1'b0;
        load_a(0, 0, 1);
        check_eq("reload_expired", a.expired_o, 0);
        a.start_stop_i = 1'b1;
        step(1);
        step(999);
        check_eq("coll_pre_ms", a.ms_o, 1);
        a.Secset = 6'd5;
        a.load_i = 1'b1;
        step(1);
        a.load_i = 1'b0;
        a.start_stop_i = 1'b0;
        check_eq("coll_sec", a.sec_o, 5);
        check_eq("coll_ms", a.ms_o, 0);
        check_eq("coll_expired", a.expired_o, 0);
        check_eq("coll_alarm", a.alarm_o, 0);
        step(1);
        check_eq("coll_alarm_after", a.alarm_o, 0);
        check_eq("coll_sec_after", a.sec_o, 5);

        // Asynchronous reset mid-RUN, then zero count must stay idle
        a.start_stop_i = 1'b1;
        step(1);
        step(10);
        check_eq("run_sec", a.sec_o, 4);
        check_eq("run_ms", a.ms_o, 990);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_sec", a.sec_o, 0);
        check_eq("async_rst_ms", a.ms_o, 0);
        #2;
        rst = 1'b0;
        step(5);
        check_eq("zero_idle_ms", a.ms_o, 0);
        check_eq("zero_idle_sec", a.sec_o, 0);
        check_eq("zero_idle_hour", a.hour_o, 0);
        check_eq("zero_idle_expired", a.expired_o, 0);
        check_eq("zero_idle_alarm", a.alarm_o, 0);
        a.start_stop_i = 1'b0;

        // Pause/resume with TICK_DIV = 4
        b.Secset = 6'd2;
        b.load_i = 1'b1;
        step(1);
        b.load_i = 1'b0;
        b.start_stop_i = 1'b1;
        step(1);
        step(3);
        check_eq("b_first_wait_ms", b.ms_o, 0);
        step(1);
        check_eq("b_first_tick_ms", b.ms_o, 999);
        step(36);
        check_eq("b_run_sec", b.sec_o, 1);
        check_eq("b_run_ms", b.ms_o, 990);
        b.start_stop_i = 1'b0;
        step(20);
        check_eq("b_pause_ms", b.ms_o, 990);
        b.start_stop_i = 1'b1;
        step(1);
        step(3);
        check_eq("b_resume_wait_ms", b.ms_o, 990);
        step(1);
        check_eq("b_resume_tick_ms", b.ms_o, 989);
        check_eq("b_resume_sec", b.sec_o, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
